// File: rtl/imm_packer.sv
// Immediate packer: checks that a value fits an instruction field and packs it into a template word.
// Optional IMM_PACK_SAT_EN: overflowing values are saturated into the field instead of truncated.
module imm_packer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      Value,
  input  logic [1:0]       Fmt,
  input  logic [15:0]      Base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      Instr,
  output logic             Ovf,
  input  logic             ClrCnt,
  output logic [CNT_W-1:0] OvfCount
);

  localparam logic [1:0] FMT_IMM5S = 2'b00;
  localparam logic [1:0] FMT_IMM5Z = 2'b01;
  localparam logic [1:0] FMT_IMM8S = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // valid/ready: a word moves on a side when valid && ready are both high at the rising edge;
  // a stalled output holds Instr/Ovf/out_valid stable until accepted.
  logic        s1_valid;
  logic        s2_valid;
  logic [15:0] s1_value;
  logic [15:0] s1_base;
  logic [1:0]  s1_fmt;
  logic        adv1;
  logic        adv2;
  logic        fit;
  logic [15:0] packed_word;

  assign adv2      = !s2_valid || out_ready;
  assign adv1      = adv2;
  assign in_ready  = !s1_valid || adv1;
  assign out_valid = s2_valid;

  always_comb begin
    fit         = 1'b0;
    packed_word = s1_base;
    case (s1_fmt)
      FMT_IMM5S: begin
        fit         = (&s1_value[15:4]) || !(|s1_value[15:4]);
        packed_word = {s1_base[15:5], s1_value[4:0]};
`ifdef IMM_PACK_SAT_EN
        if (!fit) packed_word[4:0] = s1_value[15] ? 5'h10 : 5'h0F;
`endif
      end
      FMT_IMM5Z: begin
        fit         = !(|s1_value[15:5]);
        packed_word = {s1_base[15:5], s1_value[4:0]};
`ifdef IMM_PACK_SAT_EN
        if (!fit) packed_word[4:0] = 5'h1F;
`endif
      end
      FMT_IMM8S: begin
        fit         = (&s1_value[15:7]) || !(|s1_value[15:7]);
        packed_word = {s1_base[15:8], s1_value[7:0]};
`ifdef IMM_PACK_SAT_EN
        if (!fit) packed_word[7:0] = s1_value[15] ? 8'h80 : 8'h7F;
`endif
      end
      default: begin
        fit         = (&s1_value[15:10]) || !(|s1_value[15:10]);
        packed_word = {s1_base[15:11], s1_value[10:0]};
`ifdef IMM_PACK_SAT_EN
        if (!fit) packed_word[10:0] = s1_value[15] ? 11'h400 : 11'h3FF;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_value <= 16'h0000;
      s1_base  <= 16'h0000;
      s1_fmt   <= 2'b00;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_value <= Value;
        s1_base  <= Base;
        s1_fmt   <= Fmt;
      end
    end
  end

  // Bubbles clear s2_valid but leave Instr/Ovf at their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      Instr    <= 16'h0000;
      Ovf      <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Instr <= packed_word;
        Ovf   <= !fit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OvfCount <= '0;
    end else if (ClrCnt) begin
      OvfCount <= '0;
    end else if (s2_valid && out_ready && Ovf && (OvfCount != CNT_MAX)) begin
      OvfCount <= OvfCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_packer.sv
// Bench for imm_packer: range-based reference model with an expected queue, plus directed literal checks.
module tb_imm_packer;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      value = 16'h0000;
  logic [1:0]       fmt = 2'b00;
  logic [15:0]      base = 16'h0000;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [15:0]      instr;
  logic             ovf;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] ovf_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [16:0] exp_q[$];

  imm_packer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Value(value), .Fmt(fmt), .Base(base),
    .out_valid(out_valid), .out_ready(out_ready),
    .Instr(instr), .Ovf(ovf),
    .ClrCnt(clr_cnt), .OvfCount(ovf_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference: field width and numeric range per format; result is {ovf, instr}.
  function automatic logic [16:0] model(input logic [15:0] v, input logic [1:0] f, input logic [15:0] b);
    int sv;
    int n;
    int lo;
    int hi;
    int mask;
    int field;
    bit ok;
    logic [15:0] w;
    sv = int'($signed(v));
    case (f)
      2'b00:   begin n = 5;  lo = -16;   hi = 15;   end
      2'b01:   begin n = 5;  lo = 0;     hi = 31;   end
      2'b10:   begin n = 8;  lo = -128;  hi = 127;  end
      default: begin n = 11; lo = -1024; hi = 1023; end
    endcase
    if (f == 2'b01) ok = (int'(v) <= hi);
    else ok = (sv >= lo) && (sv <= hi);
    mask = (1 << n) - 1;
    field = int'(v) & mask;
`ifdef IMM_PACK_SAT_EN
    if (!ok) field = (f != 2'b01 && sv < 0) ? (lo & mask) : hi;
`endif
    w = 16'((int'(b) & ~mask) | field);
    return {!ok, w};
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      bit inc;
      inc = 1'b0;
      check("ovf_count", 32'(ovf_count), exp_cnt);
      check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          check("instr", instr, exp_q[0][15:0]);
          check("ovf", ovf, exp_q[0][16]);
          if (out_ready) begin
            inc = exp_q[0][16];
            void'(exp_q.pop_front());
          end
        end
      end
      if (clr_cnt) exp_cnt = 0;
      else if (inc && exp_cnt < CNT_MAX) exp_cnt++;
      if (in_valid && in_ready) exp_q.push_back(model(value, fmt, base));
    end
  end

  // driver tasks: called #1 after a rising edge, return #1 after the accepting edge
  task automatic send(input logic [15:0] v, input logic [1:0] f, input logic [15:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    value = v;
    fmt = f;
    base = b;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("out_valid_timeout", out_valid, 1'b1);
  endtask

  task automatic expect_word(input string name, input logic [15:0] e_instr, input logic e_ovf);
    wait_out();
    check(name, instr, e_instr);
    check({name, "_ovf"}, ovf, e_ovf);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  logic [15:0] bnd_v[8] = '{16'h000F, 16'h0010, 16'hFF80, 16'hFF7F,
                            16'h03FF, 16'h0400, 16'hFBFF, 16'h0000};
  logic [1:0]  bnd_f[8] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01};

  initial begin
    check("model_pin_imm5s", model(16'hFFF0, 2'b00, 16'h4000), 17'h04010);
    check("model_pin_dis11", model(16'hFC00, 2'b11, 16'h2000), 17'h02400);
`ifdef IMM_PACK_SAT_EN
    check("model_pin_imm8s", model(16'h0080, 2'b10, 16'hC000), 17'h1C07F);
`else
    check("model_pin_imm8s", model(16'h0080, 2'b10, 16'hC000), 17'h1C080);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_instr", instr, 16'h0000);
    check("rst_ovf", ovf, 1'b0);
    check("rst_count", 32'(ovf_count), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'hFFF0, 2'b00, 16'h4000);
    in_valid = 1'b0;
    expect_word("imm5s_min", 16'h4010, 1'b0);
    @(posedge clk);
    #1;
    check("count_after_fit", 32'(ovf_count), 0);

    send(16'h0080, 2'b10, 16'hC000);
    in_valid = 1'b0;
`ifdef IMM_PACK_SAT_EN
    expect_word("imm8s_over", 16'hC07F, 1'b1);
`else
    expect_word("imm8s_over", 16'hC080, 1'b1);
`endif
    @(posedge clk);
    #1;
    check("count_after_ovf", 32'(ovf_count), 1);

    send(16'h001F, 2'b01, 16'h0000);
    in_valid = 1'b0;
    expect_word("imm5z_max", 16'h001F, 1'b0);
    @(posedge clk);
    #1;
    send(16'h0020, 2'b01, 16'h0000);
    in_valid = 1'b0;
`ifdef IMM_PACK_SAT_EN
    expect_word("imm5z_over", 16'h001F, 1'b1);
`else
    expect_word("imm5z_over", 16'h0000, 1'b1);
`endif
    @(posedge clk);
    #1;
    check("count_two", 32'(ovf_count), 2);

    send(16'hFC00, 2'b11, 16'h2000);
    in_valid = 1'b0;
    expect_word("dis11_min", 16'h2400, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) send(bnd_v[i], bnd_f[i], 16'hFFFF);
    drain();

    // back-to-back with a three-cycle output stall
    out_ready = 1'b0;
    send(16'h0001, 2'b11, 16'h0000);
    send(16'h0002, 2'b11, 16'h0000);
    value = 16'h0003;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_instr", instr, 16'h0001);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(16'h0003, 2'b11, 16'h0000);
    send(16'h0004, 2'b11, 16'h0000);
    drain();

    for (int i = 0; i < 300; i++) send(16'hFFFF, 2'b01, 16'hA5A5);
    drain();
    check("count_saturated", 32'(ovf_count), 255);

    send(16'h0100, 2'b00, 16'h0000);
    in_valid = 1'b0;
    wait_out();
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    check("clr_wins", 32'(ovf_count), 0);
    send(16'h8000, 2'b10, 16'h0000);
    drain();
    check("count_after_clr", 32'(ovf_count), 1);

    // reset with two words in flight
    out_ready = 1'b0;
    send(16'h0003, 2'b00, 16'h1111);
    send(16'h0004, 2'b00, 16'h2222);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_count", 32'(ovf_count), 0);
    check("midrst_instr", instr, 16'h0000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_out", out_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
